// File: rtl/dram_cmd_target.sv
// DRAM-side command target: tracks per-bank open/row state, times each command and acknowledges it.
// Optional per-command statistics counters are enabled with DRAM_CMD_TARGET_STATS_EN.
module dram_cmd_target #(
    parameter int NUM_OF_BANKS = 8,
    parameter int NUM_OF_ROWS  = 128,
    parameter int NUM_OF_COLS  = 8,
    parameter int T_RCD        = 3,
    parameter int T_CAS        = 2,
    parameter int T_RP         = 3,
    parameter int T_RFC        = 8,
    parameter int CNT_WIDTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    cmd_req,
    input  logic [1:0]              cmd,
    input  logic [NUM_OF_BANKS-1:0] bank_sel,
    input  logic [NUM_OF_ROWS-1:0]  row_sel,
    input  logic [NUM_OF_COLS-1:0]  col_sel,
    output logic                    cmd_ack,
    output logic                    err,
    output logic [2:0]              err_code,
    output logic [NUM_OF_BANKS-1:0] bank_open
`ifdef DRAM_CMD_TARGET_STATS_EN
    ,
    output logic [15:0]             stat_act,
    output logic [15:0]             stat_col,
    output logic [15:0]             stat_ref
`endif
);

    localparam int BW = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1;
    localparam int RW = (NUM_OF_ROWS > 1) ? $clog2(NUM_OF_ROWS) : 1;

    localparam logic [1:0] CMD_REF = 2'b00;
    localparam logic [1:0] CMD_ACT = 2'b01;
    localparam logic [1:0] CMD_COL = 2'b10;
    localparam logic [1:0] CMD_PRE = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_BUSY, S_ACK} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              cmd_q, cmd_d;
    logic [NUM_OF_BANKS-1:0] bsel_q, bsel_d;
    logic [NUM_OF_ROWS-1:0]  rsel_q, rsel_d;
    logic [NUM_OF_COLS-1:0]  csel_q, csel_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic [2:0]              err_code_q, err_code_d;
    logic                    rej_q, rej_d;
    logic [BW-1:0]           bidx_q, bidx_d;
    logic [RW-1:0]           ridx_q, ridx_d;
    logic [NUM_OF_BANKS-1:0] bank_open_q, bank_open_d;
    logic [RW-1:0]           open_row_q [NUM_OF_BANKS];
    logic [RW-1:0]           open_row_d [NUM_OF_BANKS];
`ifdef DRAM_CMD_TARGET_STATS_EN
    logic [15:0]             stat_act_q, stat_act_d;
    logic [15:0]             stat_col_q, stat_col_d;
    logic [15:0]             stat_ref_q, stat_ref_d;
`endif

    // Decode of the registered selects: exactly-one-bit detection plus index
    logic          b_seen, b_multi, r_seen, r_multi, c_seen, c_multi;
    logic          b_ok, r_ok, c_ok;
    logic [BW-1:0] b_idx;
    logic [RW-1:0] r_idx;
    logic [2:0]    dec_code;
    logic [CNT_WIDTH-1:0] dec_lat;

    always_comb begin
        b_seen = 1'b0; b_multi = 1'b0; b_idx = '0;
        r_seen = 1'b0; r_multi = 1'b0; r_idx = '0;
        c_seen = 1'b0; c_multi = 1'b0;
        for (int i = 0; i < NUM_OF_BANKS; i++) begin
            if (bsel_q[i]) begin
                b_multi = b_seen;
                b_seen  = 1'b1;
                b_idx   = BW'(i);
            end
        end
        for (int i = 0; i < NUM_OF_ROWS; i++) begin
            if (rsel_q[i]) begin
                r_multi = r_multi | r_seen;
                r_seen  = 1'b1;
                r_idx   = RW'(i);
            end
        end
        for (int i = 0; i < NUM_OF_COLS; i++) begin
            if (csel_q[i]) begin
                c_multi = c_multi | c_seen;
                c_seen  = 1'b1;
            end
        end
        b_ok = b_seen & ~b_multi;
        r_ok = r_seen & ~r_multi;
        c_ok = c_seen & ~c_multi;
    end

    always_comb begin
        dec_code = 3'd0;
        dec_lat  = CNT_WIDTH'(T_RFC);
        case (cmd_q)
            CMD_REF: begin
                if (|bank_open_q) dec_code = 3'd5;
            end
            CMD_ACT: begin
                dec_lat = CNT_WIDTH'(T_RCD);
                if (!b_ok || !r_ok)          dec_code = 3'd1;
                else if (bank_open_q[b_idx]) dec_code = 3'd2;
            end
            CMD_COL: begin
                dec_lat = CNT_WIDTH'(T_CAS);
                if (!b_ok || !r_ok || !c_ok)         dec_code = 3'd1;
                else if (!bank_open_q[b_idx])        dec_code = 3'd3;
                else if (open_row_q[b_idx] != r_idx) dec_code = 3'd4;
            end
            default: begin
                dec_lat = CNT_WIDTH'(T_RP);
                if (!b_ok) dec_code = 3'd1;
            end
        endcase
        if (dec_code != 3'd0) dec_lat = CNT_WIDTH'(1);
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        bsel_d      = bsel_q;
        rsel_d      = rsel_q;
        csel_d      = csel_q;
        cnt_d       = cnt_q;
        ack_d       = ack_q;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        rej_d       = rej_q;
        bidx_d      = bidx_q;
        ridx_d      = ridx_q;
        bank_open_d = bank_open_q;
        open_row_d  = open_row_q;
`ifdef DRAM_CMD_TARGET_STATS_EN
        stat_act_d  = stat_act_q;
        stat_col_d  = stat_col_q;
        stat_ref_d  = stat_ref_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_req) begin
                    cmd_d   = cmd;
                    bsel_d  = bank_sel;
                    rsel_d  = row_sel;
                    csel_d  = col_sel;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                cnt_d   = dec_lat;
                rej_d   = (dec_code != 3'd0);
                err_d   = (dec_code != 3'd0);
                bidx_d  = b_idx;
                ridx_d  = r_idx;
                if (dec_code != 3'd0) err_code_d = dec_code;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
                if (cnt_q == CNT_WIDTH'(1)) begin
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                    // Bank state only changes once the latency has elapsed
                    if (!rej_q) begin
                        if (cmd_q == CMD_ACT) begin
                            bank_open_d[bidx_q] = 1'b1;
                            open_row_d[bidx_q]  = ridx_q;
                        end else if (cmd_q == CMD_PRE) begin
                            bank_open_d[bidx_q] = 1'b0;
                        end
`ifdef DRAM_CMD_TARGET_STATS_EN
                        if (cmd_q == CMD_ACT && stat_act_q != 16'hFFFF) stat_act_d = stat_act_q + 16'd1;
                        if (cmd_q == CMD_COL && stat_col_q != 16'hFFFF) stat_col_d = stat_col_q + 16'd1;
                        if (cmd_q == CMD_REF && stat_ref_q != 16'hFFFF) stat_ref_d = stat_ref_q + 16'd1;
`endif
                    end
                end
            end
            default: begin
                if (!cmd_req) begin
                    ack_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            bsel_q      <= '0;
            rsel_q      <= '0;
            csel_q      <= '0;
            cnt_q       <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 3'd0;
            rej_q       <= 1'b0;
            bidx_q      <= '0;
            ridx_q      <= '0;
            bank_open_q <= '0;
            for (int i = 0; i < NUM_OF_BANKS; i++) open_row_q[i] <= '0;
`ifdef DRAM_CMD_TARGET_STATS_EN
            stat_act_q  <= 16'd0;
            stat_col_q  <= 16'd0;
            stat_ref_q  <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            bsel_q      <= bsel_d;
            rsel_q      <= rsel_d;
            csel_q      <= csel_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            rej_q       <= rej_d;
            bidx_q      <= bidx_d;
            ridx_q      <= ridx_d;
            bank_open_q <= bank_open_d;
            open_row_q  <= open_row_d;
`ifdef DRAM_CMD_TARGET_STATS_EN
            stat_act_q  <= stat_act_d;
            stat_col_q  <= stat_col_d;
            stat_ref_q  <= stat_ref_d;
`endif
        end
    end

    assign cmd_ack   = ack_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign bank_open = bank_open_q;
`ifdef DRAM_CMD_TARGET_STATS_EN
    assign stat_act  = stat_act_q;
    assign stat_col  = stat_col_q;
    assign stat_ref  = stat_ref_q;
`endif

endmodule

// File: tb/tb_dram_cmd_target.sv
// Bench for dram_cmd_target: directed scenarios then random commands against a bank-state reference model.
module tb_dram_cmd_target;

    logic         clk = 1'b0;
    logic         rst_b;
    logic         cmd_req;
    logic [1:0]   cmd;
    logic [7:0]   bank_sel;
    logic [127:0] row_sel;
    logic [7:0]   col_sel;
    logic         cmd_ack;
    logic         err;
    logic [2:0]   err_code;
    logic [7:0]   bank_open;
`ifdef DRAM_CMD_TARGET_STATS_EN
    logic [15:0]  stat_act, stat_col, stat_ref;
`endif

    dram_cmd_target dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .cmd_req  (cmd_req),
        .cmd      (cmd),
        .bank_sel (bank_sel),
        .row_sel  (row_sel),
        .col_sel  (col_sel),
        .cmd_ack  (cmd_ack),
        .err      (err),
        .err_code (err_code),
        .bank_open(bank_open)
`ifdef DRAM_CMD_TARGET_STATS_EN
        ,
        .stat_act (stat_act),
        .stat_col (stat_col),
        .stat_ref (stat_ref)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: which banks are open, their rows, last error code, stat counts
    bit m_open [8];
    int m_row  [8];
    int m_code;
    int m_act, m_col, m_ref;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [127:0] v, input int w);
        int n = 0;
        int k = -1;
        for (int i = 0; i < w; i++) if (v[i]) begin n++; k = i; end
        return (n == 1) ? k : -1;
    endfunction

    function automatic logic [7:0] open_vec();
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) v[i] = m_open[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin m_open[i] = 0; m_row[i] = 0; end
        m_code = 0; m_act = 0; m_col = 0; m_ref = 0;
    endtask

    task automatic model_cmd(input logic [1:0] c, input logic [7:0] b, input logic [127:0] r,
                             input logic [7:0] cs, output int code, output int lat);
        int  bi, ri, ci;
        bit  any;
        bi  = idx_of({120'd0, b}, 8);
        ri  = idx_of(r, 128);
        ci  = idx_of({120'd0, cs}, 8);
        any = 0;
        for (int i = 0; i < 8; i++) any |= m_open[i];
        code = 0;
        case (c)
            2'b00: begin lat = 8; if (any) code = 5; end
            2'b01: begin lat = 3; if (bi < 0 || ri < 0) code = 1; else if (m_open[bi]) code = 2; end
            2'b10: begin
                lat = 2;
                if (bi < 0 || ri < 0 || ci < 0) code = 1;
                else if (!m_open[bi])           code = 3;
                else if (m_row[bi] != ri)       code = 4;
            end
            default: begin lat = 3; if (bi < 0) code = 1; end
        endcase
        if (code != 0) begin
            lat    = 1;
            m_code = code;
        end else begin
            case (c)
                2'b00: m_ref = (m_ref < 65535) ? m_ref + 1 : m_ref;
                2'b01: begin m_open[bi] = 1; m_row[bi] = ri; m_act = (m_act < 65535) ? m_act + 1 : m_act; end
                2'b10: m_col = (m_col < 65535) ? m_col + 1 : m_col;
                default: m_open[bi] = 0;
            endcase
        end
    endtask

    // Issue one command, measure ack latency, err pulse and resulting state
    task automatic run_cmd(input logic [1:0] c, input logic [7:0] b, input logic [127:0] r, input logic [7:0] cs);
        int  code, lat, n;
        bit  got;
        logic e2, e3;
        model_cmd(c, b, r, cs, code, lat);
        @(negedge clk);
        cmd = c; bank_sel = b; row_sel = r; col_sel = cs; cmd_req = 1'b1;
        n = 0; got = 0; e2 = 1'bx; e3 = 1'bx;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 2) e2 = err;
            if (n == 3) e3 = err;
            if (cmd_ack) begin got = 1; break; end
        end
        chk("ack_latency", got ? n - 1 : 0, lat + 1);
        chk("err_pulse", e2, (code != 0));
        chk("err_single", e3, 1'b0);
        chk("err_code", err_code, m_code);
        chk("bank_open", bank_open, open_vec());
        @(negedge clk);
        cmd_req = 1'b0;
        cmd = 2'($urandom); bank_sel = 8'($urandom);
        @(posedge clk); #1;
        chk("ack_fall", cmd_ack, 1'b0);
`ifdef DRAM_CMD_TARGET_STATS_EN
        chk("stat_act", stat_act, m_act);
        chk("stat_col", stat_col, m_col);
        chk("stat_ref", stat_ref, m_ref);
`endif
    endtask

    function automatic logic [127:0] row1(input int k);
        logic [127:0] v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   rc;
        logic [7:0]   rb, rcs;
        logic [127:0] rr;
        int           sel;
        rst_b = 1'b0; cmd_req = 1'b0; cmd = '0; bank_sel = '0; row_sel = '0; col_sel = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", cmd_ack, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_err_code", err_code, 3'd0);
        chk("rst_bank_open", bank_open, 8'h00);
        @(negedge clk);
        rst_b = 1'b1;

        run_cmd(2'b01, 8'h04, row1(5), 8'h00);
        chk("act_b2_open", bank_open, 8'h04);
        run_cmd(2'b10, 8'h04, row1(5), 8'h08);
        run_cmd(2'b10, 8'h04, row1(6), 8'h08);
        chk("col_mismatch_code", err_code, 3'd4);
        run_cmd(2'b01, 8'h04, row1(9), 8'h00);
        chk("act_open_code", err_code, 3'd2);
        run_cmd(2'b11, 8'h04, '0, 8'h00);
        chk("pre_b2_closed", bank_open, 8'h00);
        run_cmd(2'b11, 8'h04, '0, 8'h00);
        run_cmd(2'b01, 8'h01, row1(1), 8'h00);
        run_cmd(2'b00, 8'h00, '0, 8'h00);
        chk("ref_open_code", err_code, 3'd5);
        run_cmd(2'b11, 8'h01, '0, 8'h00);
        run_cmd(2'b00, 8'h00, '0, 8'h00);
        run_cmd(2'b01, 8'h06, row1(2), 8'h00);
        chk("bad_onehot_code", err_code, 3'd1);
        run_cmd(2'b10, 8'h02, row1(0), 8'h01);
        chk("col_closed_code", err_code, 3'd3);

        // Statistics scenario: three accepted ACT/PRE pairs and one rejected ACT
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_cmd(2'b01, 8'h10, row1(i + 3), 8'h00);
            run_cmd(2'b11, 8'h10, '0, 8'h00);
        end
        run_cmd(2'b01, 8'h30, row1(1), 8'h00);
        chk("stats_act_model", m_act, 3);

        for (int t = 0; t < 120; t++) begin
            sel = $urandom_range(0, 9);
            rc  = (sel < 2) ? 2'b00 : (sel < 5) ? 2'b01 : (sel < 7) ? 2'b10 : 2'b11;
            rb  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
            rr  = ($urandom_range(0, 19) == 0) ? 128'd0 : row1($urandom_range(0, 3));
            rcs = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
            run_cmd(rc, rb, rr, rcs);
        end

        // Reset asserted during BUSY of a legal ACTIVATE with another bank open
        run_cmd(2'b11, 8'h08, '0, 8'h00);
        run_cmd(2'b01, 8'h08, row1(7), 8'h00);
        @(negedge clk);
        cmd = 2'b01; bank_sel = 8'h40; row_sel = row1(2); col_sel = '0; cmd_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_b = 1'b0;
        #1;
        chk("midrst_ack", cmd_ack, 1'b0);
        chk("midrst_bank_open", bank_open, 8'h00);
        chk("midrst_err_code", err_code, 3'd0);
        cmd_req = 1'b0;
        model_reset();
        @(negedge clk);
        rst_b = 1'b1;
        run_cmd(2'b10, 8'h08, row1(7), 8'h01);
        chk("post_rst_col_code", err_code, 3'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
